// File: rtl/status_irq_reg.sv
// Sticky status / interrupt register. Each status line is captured per bit as a level or an edge.
// Optional overflow tracking is enabled by defining STATUS_IRQ_OVF_EN.

module status_irq_bit #(
  parameter logic EDGE  = 1'b0,
  parameter logic POL   = 1'b1,
  parameter logic RST_M = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_armed,
  input  logic i_status,
  input  logic i_w1c,
  input  logic i_w1c_ovf,
  input  logic i_clr,
  input  logic i_mask_we,
  input  logic i_mask_d,
  output logic o_sts,
  output logic o_mask,
  output logic o_raw,
  output logic o_ovf
);
  logic r_sts, r_mask, r_raw;
  logic w_edge, w_evt;

  assign w_edge = POL ? (i_status & ~r_raw) : (~i_status & r_raw);
  assign w_evt  = EDGE ? (i_armed & w_edge) : i_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sts  <= 1'b0;
      r_mask <= RST_M;
      r_raw  <= 1'b0;
    end else begin
      r_raw <= i_status;
      // a new event outranks a same-cycle W1C so it is never lost
      r_sts <= i_clr ? 1'b0 : ((r_sts & ~i_w1c) | w_evt);
      if (i_mask_we) r_mask <= i_mask_d;
    end
  end

`ifdef STATUS_IRQ_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else     r_ovf <= i_clr ? 1'b0 : ((r_ovf & ~i_w1c_ovf) | (w_evt & r_sts & ~i_w1c));
  end
  assign o_ovf = r_ovf;
`else
  logic w_unused;
  assign w_unused = i_w1c_ovf;
  assign o_ovf    = 1'b0;
`endif

  assign o_sts  = r_sts;
  assign o_mask = r_mask;
  assign o_raw  = r_raw;
endmodule

module status_irq_reg #(
  parameter int            DW        = 8,
  parameter logic [DW-1:0] RST_MASK  = {DW{1'b0}},
  parameter logic [DW-1:0] EDGE_MODE = {DW{1'b0}},
  parameter logic [DW-1:0] EDGE_POL  = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpuren_i,
  input  logic          cpuwen_i,
  input  logic [1:0]    cpuaddr_i,
  input  logic [DW-1:0] cpudi_i,
  output logic [DW-1:0] cpudo_o,
  input  logic [DW-1:0] status_i,
  input  logic          clr_i,
  output logic          irq_o
);
  typedef struct packed {
    logic       ren;
    logic       wen;
    logic [1:0] addr;
  } cpu_req_t;

  cpu_req_t      w_req;
  logic          r_armed;
  logic          w_mask_we;
  logic [DW-1:0] w_w1c, w_w1c_ovf;
  logic [DW-1:0] w_sts, w_mask, w_raw, w_ovf;

  assign w_req     = '{ren: cpuren_i, wen: cpuwen_i, addr: cpuaddr_i};
  assign w_w1c     = (w_req.wen && w_req.addr == 2'd0) ? cpudi_i : '0;
  assign w_w1c_ovf = (w_req.wen && w_req.addr == 2'd3) ? cpudi_i : '0;
  assign w_mask_we = w_req.wen && (w_req.addr == 2'd1);

  // raw_q holds its reset value during the first cycle, so edges are not trusted until then
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_armed <= 1'b0;
    else     r_armed <= 1'b1;
  end

  for (genvar i = 0; i < DW; i++) begin : g_bit
    status_irq_bit #(
      .EDGE (EDGE_MODE[i]),
      .POL  (EDGE_POL[i]),
      .RST_M(RST_MASK[i])
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .i_armed  (r_armed),
      .i_status (status_i[i]),
      .i_w1c    (w_w1c[i]),
      .i_w1c_ovf(w_w1c_ovf[i]),
      .i_clr    (clr_i),
      .i_mask_we(w_mask_we),
      .i_mask_d (cpudi_i[i]),
      .o_sts    (w_sts[i]),
      .o_mask   (w_mask[i]),
      .o_raw    (w_raw[i]),
      .o_ovf    (w_ovf[i])
    );
  end

  assign irq_o = |(w_sts & w_mask);

  always_comb begin
    cpudo_o = '0;
    if (w_req.ren) begin
      case (w_req.addr)
        2'd0:    cpudo_o = w_sts;
        2'd1:    cpudo_o = w_mask;
        2'd2:    cpudo_o = w_raw;
        default: cpudo_o = w_ovf;
      endcase
    end
  end
endmodule

// File: tb/tb_status_irq_reg.sv
// Bench for status_irq_reg: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a vector-level model of the register rules.

module tb_status_irq_reg;
  localparam logic [7:0] RST_MASK  = 8'h0F;
  localparam logic [7:0] EDGE_MODE = 8'hF0; // 0-3 level, 4-5 rising, 6-7 falling
  localparam logic [7:0] EDGE_POL  = 8'h30;
`ifdef STATUS_IRQ_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpuren_i = 1'b0, cpuwen_i = 1'b0, clr_i = 1'b0;
  logic [1:0] cpuaddr_i = 2'd0;
  logic [7:0] cpudi_i = 8'h00, status_i = 8'hFF, cpudo_o;
  logic       irq_o;

  int         n_vec = 0, n_err = 0;
  logic       check_en = 1'b0;
  logic [7:0] cur_st = 8'hFF;

  logic [7:0] m_sts = 8'h00, m_mask = RST_MASK, m_raw = 8'h00, m_ovf = 8'h00;
  logic       m_armed = 1'b0;

  status_irq_reg #(.DW(8), .RST_MASK(RST_MASK), .EDGE_MODE(EDGE_MODE), .EDGE_POL(EDGE_POL)) dut (
    .clk(clk), .rst(rst), .cpuren_i(cpuren_i), .cpuwen_i(cpuwen_i), .cpuaddr_i(cpuaddr_i),
    .cpudi_i(cpudi_i), .cpudo_o(cpudo_o), .status_i(status_i), .clr_i(clr_i), .irq_o(irq_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] f_evt(input logic [7:0] st, input logic [7:0] raw, input logic armed);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      if (!EDGE_MODE[i])    e[i] = st[i];
      else if (!armed)      e[i] = 1'b0;
      else if (EDGE_POL[i]) e[i] = st[i] & ~raw[i];
      else                  e[i] = ~st[i] & raw[i];
    end
    return e;
  endfunction

  function automatic logic [7:0] f_wr(input logic wen, input logic [1:0] addr, input logic [1:0] a,
                                      input logic [7:0] d);
    return (wen && addr == a) ? d : 8'h00;
  endfunction

  // reference model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sts <= 8'h00; m_mask <= RST_MASK; m_raw <= 8'h00; m_ovf <= 8'h00; m_armed <= 1'b0;
    end else begin
      m_raw   <= status_i;
      m_armed <= 1'b1;
      if (cpuwen_i && cpuaddr_i == 2'd1) m_mask <= cpudi_i;
      m_sts <= clr_i ? 8'h00 :
               (m_sts & ~f_wr(cpuwen_i, cpuaddr_i, 2'd0, cpudi_i)) | f_evt(status_i, m_raw, m_armed);
      if (OVF)
        m_ovf <= clr_i ? 8'h00 :
                 (m_ovf & ~f_wr(cpuwen_i, cpuaddr_i, 2'd3, cpudi_i)) |
                 (f_evt(status_i, m_raw, m_armed) & m_sts & ~f_wr(cpuwen_i, cpuaddr_i, 2'd0, cpudi_i));
    end
  end

  // compare process
  always @(negedge clk) begin
    if (check_en) begin
      logic [7:0] exp_do;
      case (cpuaddr_i)
        2'd0:    exp_do = m_sts;
        2'd1:    exp_do = m_mask;
        2'd2:    exp_do = m_raw;
        default: exp_do = m_ovf;
      endcase
      if (!cpuren_i) exp_do = 8'h00;
      chk("model_cpudo", cpudo_o, exp_do);
      chk("model_irq", {7'b0, irq_o}, {7'b0, |(m_sts & m_mask)});
    end
  end

  task automatic apply(input logic ren, input logic wen, input logic [1:0] addr, input logic [7:0] di,
                       input logic [7:0] st, input logic clr);
    @(posedge clk); #1;
    cpuren_i = ren; cpuwen_i = wen; cpuaddr_i = addr; cpudi_i = di; status_i = st; clr_i = clr;
    cur_st = st;
  endtask

  task automatic rdchk(input logic [1:0] addr, input logic [7:0] exp, input string nm);
    apply(1'b1, 1'b0, addr, 8'h00, cur_st, 1'b0);
    #1 chk(nm, cpudo_o, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk("rst_irq", {7'b0, irq_o}, 8'h00);
    cpuren_i = 1'b1; cpuaddr_i = 2'd1;
    #1 chk("rst_mask", cpudo_o, RST_MASK);
    cpuaddr_i = 2'd0;
    #1 chk("rst_sts", cpudo_o, 8'h00);
    cpuren_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0; check_en = 1'b1;

    // status held high out of reset: level bits capture, edge bits suppressed
    rdchk(2'd0, 8'h0F, "armed_suppress");
    chk("armed_irq", {7'b0, irq_o}, 8'h01);
    apply(0, 0, 0, 8'h00, 8'h00, 0);
    rdchk(2'd0, 8'hCF, "fall_edges");
    apply(0, 1, 0, 8'hFF, 8'h00, 0);
    rdchk(2'd0, 8'h00, "w1c_all");

    // level pulse is sticky, W1C clears
    apply(0, 1, 1, 8'hFF, 8'h00, 0);
    apply(0, 0, 0, 8'h00, 8'h01, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0);
    rdchk(2'd0, 8'h01, "lvl_sticky");
    chk("lvl_irq", {7'b0, irq_o}, 8'h01);
    apply(0, 1, 0, 8'h01, 8'h00, 0);
    rdchk(2'd0, 8'h00, "lvl_w1c");
    chk("lvl_irq_clr", {7'b0, irq_o}, 8'h00);

    // two rises on bit 4 -> overflow
    apply(0, 0, 0, 8'h00, 8'h10, 0);
    apply(0, 0, 0, 8'h00, 8'h00, 0);
    apply(0, 0, 0, 8'h00, 8'h10, 0);
    rdchk(2'd0, 8'h10, "rise_sts");
    rdchk(2'd3, OVF ? 8'h10 : 8'h00, "ovf_set");
    rdchk(2'd2, 8'h10, "raw");
    apply(0, 1, 3, 8'h10, 8'h10, 0);
    rdchk(2'd3, 8'h00, "ovf_w1c");
    apply(0, 1, 0, 8'hFF, 8'h00, 0);
    rdchk(2'd0, 8'h00, "rise_clr");

    // event outranks W1C, clr outranks both
    apply(0, 1, 0, 8'h04, 8'h04, 0);
    rdchk(2'd0, 8'h04, "set_wins");
    apply(0, 1, 0, 8'h04, 8'h04, 1);
    rdchk(2'd0, 8'h00, "clr_wins");
    apply(0, 1, 0, 8'hFF, 8'h00, 0);

    // masked event, then unmask
    apply(0, 1, 1, 8'h00, 8'h00, 0);
    apply(0, 0, 0, 8'h00, 8'h20, 0);
    rdchk(2'd0, 8'h20, "mask_sts");
    chk("masked_irq", {7'b0, irq_o}, 8'h00);
    apply(0, 1, 1, 8'h20, 8'h20, 0);
    #1 chk("mask_wr_cycle", {7'b0, irq_o}, 8'h00);
    apply(0, 0, 0, 8'h00, 8'h20, 0);
    #1 chk("mask_irq", {7'b0, irq_o}, 8'h01);

    // reset while pending
    apply(0, 1, 0, 8'hFF, 8'h00, 0);
    apply(0, 1, 1, 8'hFF, 8'h00, 0);
    apply(0, 0, 0, 8'h00, 8'h80, 0);
    apply(0, 0, 0, 8'h00, 8'h2A, 0);
    rdchk(2'd0, 8'hAA, "pend_aa");
    chk("pend_irq", {7'b0, irq_o}, 8'h01);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("midrst_irq", {7'b0, irq_o}, 8'h00);
    chk("midrst_sts", cpudo_o, 8'h00);
    cpuaddr_i = 2'd1;
    #1 chk("midrst_mask", cpudo_o, RST_MASK);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // randomized run
    for (int n = 0; n < 800; n++) begin
      logic [7:0] st;
      st = cur_st ^ (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
      apply(1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom), st,
            ($urandom_range(0, 15) == 0));
      if (n == 400) begin
        #2 rst = 1'b1;
        #5 rst = 1'b0;
      end
    end

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
